// File: rtl/result_stream.sv
// Streams each accepted forward-pass result off-chip as a 4-byte frame.
// Ports:
//   clk_i, rst_i (async, active-low)
//   en_i, fpass_over_i, final_i: capture side
//   ack_i: async reader ack
//   data_o, valid_o, byte_idx_o: byte bus
//   busy_o, epoch_o, overrun_o: status
module result_stream #(
    parameter int DATA_W  = 23,
    parameter int EPOCH_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               fpass_over_i,
    input  logic [DATA_W-1:0]  final_i,
    input  logic               ack_i,
    output logic [7:0]         data_o,
    output logic               valid_o,
    output logic [1:0]         byte_idx_o,
    output logic               busy_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               overrun_o
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RELEASE
    } state_t;

    state_t            state;
    logic              ack_m;
    logic              ack_s;
    logic [DATA_W-1:0] frame_q;
    logic [DATA_W-1:0] pend_q;
    logic              pend_v;

    logic cap;
    logic last;
    logic drop;

    function automatic logic [7:0] frame_byte(
        input logic [DATA_W-1:0] f,
        input logic [1:0]        i
    );
        logic [22:0] w;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        w  = f;
        b0 = w[7:0];
        b1 = w[15:8];
        b2 = {1'b0, w[22:16]};
        case (i)
            2'd0:    frame_byte = b0;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
            default: frame_byte = b0 ^ b1 ^ b2;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack_i;
            ack_s <= ack_m;
        end
    end

    assign cap  = fpass_over_i & en_i;
    // Final release edge of a frame: the FSM leaves RELEASE after byte 3.
    assign last = (state == RELEASE) && !ack_s && (byte_idx_o == 2'd3);
    // A full pending slot is only safe when it is being drained this edge.
    assign drop = cap && (state != IDLE) && pend_v && !last;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            frame_q    <= '0;
            pend_q     <= '0;
            pend_v     <= 1'b0;
            data_o     <= 8'd0;
            valid_o    <= 1'b0;
            byte_idx_o <= 2'd0;
            busy_o     <= 1'b0;
            epoch_o    <= '0;
            overrun_o  <= 1'b0;
        end else begin
            if (cap && !drop)
                epoch_o <= epoch_o + 1'b1;
            if (drop)
                overrun_o <= 1'b1;
            // Busy, slot free, not at the frame boundary: park in pending.
            if (cap && (state != IDLE) && !pend_v && !last) begin
                pend_q <= final_i;
                pend_v <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cap) begin
                        frame_q    <= final_i;
                        byte_idx_o <= 2'd0;
                        data_o     <= frame_byte(final_i, 2'd0);
                        valid_o    <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (ack_s) begin
                        valid_o <= 1'b0;
                        data_o  <= 8'd0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        if (byte_idx_o != 2'd3) begin
                            byte_idx_o <= byte_idx_o + 2'd1;
                            data_o     <= frame_byte(frame_q, byte_idx_o + 2'd1);
                            valid_o    <= 1'b1;
                            state      <= SEND;
                        end else if (pend_v) begin
                            frame_q    <= pend_q;
                            byte_idx_o <= 2'd0;
                            data_o     <= frame_byte(pend_q, 2'd0);
                            valid_o    <= 1'b1;
                            state      <= SEND;
                            if (cap)
                                pend_q <= final_i;
                            else
                                pend_v <= 1'b0;
                        end else if (cap) begin
                            // Back-to-back frame without an IDLE cycle.
                            frame_q    <= final_i;
                            byte_idx_o <= 2'd0;
                            data_o     <= frame_byte(final_i, 2'd0);
                            valid_o    <= 1'b1;
                            state      <= SEND;
                        end else begin
                            byte_idx_o <= 2'd0;
                            busy_o     <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
